// File: rtl/tl_ul_sram_responder_if.sv
// TileLink-UL A/D channel bundle for a single-beat, 32-bit data bus.
// The master modport is the requesting agent; the slave modport is the responder.
//
// Handshake: a beat on either channel transfers on a rising clock edge where
// valid && ready. Once valid is raised, the sender holds valid and every
// payload field stable until that transfer edge. ready may depend on the
// receiver's own state, but never on the sender's valid.
interface tl_ul_sram_responder_if #(
    parameter int SOURCE_W = 4
);
    // A channel (request)
    logic                a_valid;
    logic                a_ready;
    logic [2:0]          a_opcode;
    logic [2:0]          a_param;
    logic [1:0]          a_size;
    logic [SOURCE_W-1:0] a_source;
    logic [31:0]         a_address;
    logic [3:0]          a_mask;
    logic [31:0]         a_data;
    logic                a_corrupt;

    // D channel (response)
    logic                d_valid;
    logic                d_ready;
    logic [2:0]          d_opcode;
    logic [1:0]          d_param;
    logic [1:0]          d_size;
    logic [SOURCE_W-1:0] d_source;
    logic                d_sink;
    logic                d_denied;
    logic                d_corrupt;
    logic [31:0]         d_data;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address,
               a_mask, a_data, a_corrupt, d_ready,
        input  a_ready, d_valid, d_opcode, d_param, d_size, d_source,
               d_sink, d_denied, d_corrupt, d_data
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address,
               a_mask, a_data, a_corrupt, d_ready,
        output a_ready, d_valid, d_opcode, d_param, d_size, d_source,
               d_sink, d_denied, d_corrupt, d_data
    );
endinterface

// File: rtl/tl_ul_sram_responder.sv
// TileLink-UL responder backed by a small flop-based word memory.
// Accepts single-beat Get / PutFullData / PutPartialData requests and answers
// each with one D beat one cycle later from a single response register.
// Illegal requests are answered with d_denied=1 and leave memory untouched.
//
// Optional: define TL_UL_SRAM_RESPONDER_ERRCNT_EN to add a saturating 8-bit
// count of denied D beats (err_count) with a synchronous clear (err_clear).
module tl_ul_sram_responder #(
    parameter int          SOURCE_W = 4,
    parameter int          DEPTH    = 16,
    parameter logic [31:0] BASE     = 32'h0000_0000
) (
    input  logic clock,
    input  logic reset,
`ifdef TL_UL_SRAM_RESPONDER_ERRCNT_EN
    input  logic       err_clear,
    output logic [7:0] err_count,
`endif
    tl_ul_sram_responder_if.slave tl
);
    localparam int          IDX_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] REGION_BYTES = 33'(DEPTH) * 33'd4;

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;

    // Response register
    logic                r_d_valid;
    logic [2:0]          r_d_opcode;
    logic [1:0]          r_d_size;
    logic [SOURCE_W-1:0] r_d_source;
    logic                r_d_denied;
    logic                r_d_corrupt;
    logic [31:0]         r_d_data;

    // Word memory
    logic [31:0] r_mem [DEPTH];

    // Request decode
    logic             w_accept;
    logic             w_d_fire;
    logic             w_is_get;
    logic             w_is_put_full;
    logic             w_is_put_partial;
    logic             w_is_put;
    logic             w_opcode_ok;
    logic             w_param_ok;
    logic             w_size_ok;
    logic             w_in_region;
    logic             w_aligned;
    logic [3:0]       w_lanes;
    logic             w_mask_ok;
    logic             w_denied;
    logic             w_do_write;
    logic [32:0]      w_offset;
    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_rdata;
    logic             w_unused;

    // The responder can take a new beat whenever the response slot is empty
    // or is being drained this cycle; held off entirely during reset.
    assign tl.a_ready = reset && (!r_d_valid || tl.d_ready);
    assign w_accept   = tl.a_valid && tl.a_ready;
    assign w_d_fire   = r_d_valid && tl.d_ready;

    // Byte offset into the region; the extra top bit flags addresses below BASE.
    assign w_offset = {1'b0, tl.a_address} - {1'b0, BASE};
    assign w_idx    = w_offset[IDX_W+1:2];
    assign w_rdata  = r_mem[w_idx];
    assign w_unused = ^{w_offset[32:IDX_W+2], w_offset[1:0]};

    // Legality checks and byte-lane decode for the A beat currently presented.
    always_comb begin
        w_is_get         = (tl.a_opcode == OP_GET);
        w_is_put_full    = (tl.a_opcode == OP_PUT_FULL);
        w_is_put_partial = (tl.a_opcode == OP_PUT_PARTIAL);
        w_is_put         = w_is_put_full || w_is_put_partial;
        w_opcode_ok      = w_is_get || w_is_put;
        w_param_ok       = (tl.a_param == 3'd0);
        w_size_ok        = (tl.a_size <= 2'd2);
        w_in_region      = !w_offset[32] && (w_offset < REGION_BYTES);

        w_aligned = 1'b0;
        w_lanes   = 4'b0000;
        case (tl.a_size)
            2'd0: begin
                w_aligned = 1'b1;
                w_lanes   = 4'b0001 << tl.a_address[1:0];
            end
            2'd1: begin
                w_aligned = (tl.a_address[0] == 1'b0);
                w_lanes   = tl.a_address[1] ? 4'b1100 : 4'b0011;
            end
            2'd2: begin
                w_aligned = (tl.a_address[1:0] == 2'b00);
                w_lanes   = 4'b1111;
            end
            default: begin
                w_aligned = 1'b0;
                w_lanes   = 4'b0000;
            end
        endcase

        // Full-width ops must name exactly the implied lanes; partial puts may
        // name any subset of them.
        if (w_is_put_partial) begin
            w_mask_ok = ((tl.a_mask & ~w_lanes) == 4'b0000);
        end else begin
            w_mask_ok = (tl.a_mask == w_lanes);
        end

        // Poisoned write data is treated as a rejected write.
        w_denied = !w_opcode_ok || !w_param_ok || !w_size_ok || !w_in_region ||
                   !w_aligned || !w_mask_ok || (w_is_put && tl.a_corrupt);

        w_do_write = w_accept && w_is_put && !w_denied;
    end

    // Response register: load on accept, empty after a drain with no refill.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_d_valid   <= 1'b0;
            r_d_opcode  <= 3'd0;
            r_d_size    <= 2'd0;
            r_d_source  <= '0;
            r_d_denied  <= 1'b0;
            r_d_corrupt <= 1'b0;
            r_d_data    <= 32'd0;
        end else if (w_accept) begin
            r_d_valid   <= 1'b1;
            r_d_opcode  <= w_is_get ? OP_ACCESS_ACK_DATA : OP_ACCESS_ACK;
            r_d_size    <= tl.a_size;
            r_d_source  <= tl.a_source;
            r_d_denied  <= w_denied;
            r_d_corrupt <= w_denied && w_is_get;
            // Read sees the pre-write value; Gets never write so this is exact.
            r_d_data    <= (w_is_get && !w_denied) ? w_rdata : 32'd0;
        end else if (w_d_fire) begin
            r_d_valid <= 1'b0;
        end
    end

    // Memory: byte-lane writes for accepted, legal Puts.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else if (w_do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (tl.a_mask[b]) begin
                    r_mem[w_idx][8*b +: 8] <= tl.a_data[8*b +: 8];
                end
            end
        end
    end

    assign tl.d_valid   = r_d_valid;
    assign tl.d_opcode  = r_d_opcode;
    assign tl.d_param   = 2'd0;
    assign tl.d_size    = r_d_size;
    assign tl.d_source  = r_d_source;
    assign tl.d_sink    = 1'b0;
    assign tl.d_denied  = r_d_denied;
    assign tl.d_corrupt = r_d_corrupt;
    assign tl.d_data    = r_d_data;

`ifdef TL_UL_SRAM_RESPONDER_ERRCNT_EN
    logic [7:0] r_err_count;

    // Saturating count of denied beats delivered; clear wins over increment.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_err_count <= 8'd0;
        end else if (err_clear) begin
            r_err_count <= 8'd0;
        end else if (w_d_fire && r_d_denied && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_tl_ul_sram_responder.sv
// Directed testbench for tl_ul_sram_responder (DEPTH=16, BASE=0, SOURCE_W=4).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_tl_ul_sram_responder;
    logic clock;
    logic reset;
`ifdef TL_UL_SRAM_RESPONDER_ERRCNT_EN
    logic       err_clear;
    logic [7:0] err_count;
`endif

    int n_cmp;
    int n_err;

    tl_ul_sram_responder_if #(.SOURCE_W(4)) tl ();

    tl_ul_sram_responder #(
        .SOURCE_W(4),
        .DEPTH   (16),
        .BASE    (32'h0000_0000)
    ) dut (
        .clock    (clock),
        .reset    (reset),
`ifdef TL_UL_SRAM_RESPONDER_ERRCNT_EN
        .err_clear(err_clear),
        .err_count(err_count),
`endif
        .tl       (tl)
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic idle();
        @(posedge clock);
        #1;
    endtask

    // Present one A beat, expect it accepted on the next edge, then drop a_valid.
    task automatic do_a(input logic [2:0] op, input logic [2:0] prm, input logic [1:0] sz,
                        input logic [3:0] src, input logic [31:0] addr, input logic [3:0] msk,
                        input logic [31:0] dat, input logic cor);
        tl.a_opcode  = op;
        tl.a_param   = prm;
        tl.a_size    = sz;
        tl.a_source  = src;
        tl.a_address = addr;
        tl.a_mask    = msk;
        tl.a_data    = dat;
        tl.a_corrupt = cor;
        tl.a_valid   = 1'b1;
        #1;
        chk("a_ready_before_accept", 32'(tl.a_ready), 32'd1);
        @(posedge clock);
        #1;
        tl.a_valid = 1'b0;
    endtask

    task automatic check_d(input string tag, input logic [2:0] op, input logic [3:0] src,
                           input logic [1:0] sz, input logic den, input logic cor,
                           input logic [31:0] dat);
        chk({tag, ".d_valid"},   32'(tl.d_valid),   32'd1);
        chk({tag, ".d_opcode"},  32'(tl.d_opcode),  32'(op));
        chk({tag, ".d_source"},  32'(tl.d_source),  32'(src));
        chk({tag, ".d_size"},    32'(tl.d_size),    32'(sz));
        chk({tag, ".d_denied"},  32'(tl.d_denied),  32'(den));
        chk({tag, ".d_corrupt"}, 32'(tl.d_corrupt), 32'(cor));
        chk({tag, ".d_data"},    tl.d_data,         dat);
        chk({tag, ".d_param"},   32'(tl.d_param),   32'd0);
        chk({tag, ".d_sink"},    32'(tl.d_sink),    32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset        = 1'b0;
        tl.a_valid   = 1'b0;
        tl.a_opcode  = 3'd0;
        tl.a_param   = 3'd0;
        tl.a_size    = 2'd0;
        tl.a_source  = 4'd0;
        tl.a_address = 32'd0;
        tl.a_mask    = 4'd0;
        tl.a_data    = 32'd0;
        tl.a_corrupt = 1'b0;
        tl.d_ready   = 1'b1;
`ifdef TL_UL_SRAM_RESPONDER_ERRCNT_EN
        err_clear = 1'b0;
`endif

        // Reset state
        repeat (3) idle();
        chk("reset.d_valid", 32'(tl.d_valid), 32'd0);
        chk("reset.a_ready", 32'(tl.a_ready), 32'd0);
        chk("reset.d_data",  tl.d_data,       32'd0);
        chk("reset.d_denied", 32'(tl.d_denied), 32'd0);
        reset = 1'b1;
        idle();

        // PutFullData then Get of the same word
        do_a(3'd0, 3'd0, 2'd2, 4'd3, 32'd8, 4'hF, 32'hDEADBEEF, 1'b0);
        check_d("put_full", 3'd0, 4'd3, 2'd2, 1'b0, 1'b0, 32'd0);
        do_a(3'd4, 3'd0, 2'd2, 4'd5, 32'd8, 4'hF, 32'd0, 1'b0);
        check_d("get_full", 3'd1, 4'd5, 2'd2, 1'b0, 1'b0, 32'hDEADBEEF);

        // Byte write to lane 1 of word 2, read back the merged word
        do_a(3'd1, 3'd0, 2'd0, 4'd6, 32'd9, 4'b0010, 32'h0000AA00, 1'b0);
        check_d("put_partial", 3'd0, 4'd6, 2'd0, 1'b0, 1'b0, 32'd0);
        do_a(3'd4, 3'd0, 2'd2, 4'd7, 32'd8, 4'hF, 32'd0, 1'b0);
        check_d("get_partial", 3'd1, 4'd7, 2'd2, 1'b0, 1'b0, 32'hDEADAAEF);

        // Partial put whose lane lies outside the byte addressed: rejected, no write
        do_a(3'd1, 3'd0, 2'd0, 4'd2, 32'd8, 4'b0010, 32'h00001100, 1'b0);
        check_d("put_partial_bad_lane", 3'd0, 4'd2, 2'd0, 1'b1, 1'b0, 32'd0);
        do_a(3'd4, 3'd0, 2'd2, 4'd2, 32'd8, 4'hF, 32'd0, 1'b0);
        check_d("get_after_bad_lane", 3'd1, 4'd2, 2'd2, 1'b0, 1'b0, 32'hDEADAAEF);

        // Populate word 3
        do_a(3'd0, 3'd0, 2'd2, 4'd1, 32'd12, 4'hF, 32'h11223344, 1'b0);
        check_d("put_word3", 3'd0, 4'd1, 2'd2, 1'b0, 1'b0, 32'd0);

        // Four back-to-back Gets: one D beat per cycle, no bubbles
        do_a(3'd4, 3'd0, 2'd2, 4'd10, 32'd0, 4'hF, 32'd0, 1'b0);
        check_d("b2b0", 3'd1, 4'd10, 2'd2, 1'b0, 1'b0, 32'd0);
        do_a(3'd4, 3'd0, 2'd2, 4'd11, 32'd4, 4'hF, 32'd0, 1'b0);
        check_d("b2b1", 3'd1, 4'd11, 2'd2, 1'b0, 1'b0, 32'd0);
        do_a(3'd4, 3'd0, 2'd2, 4'd12, 32'd8, 4'hF, 32'd0, 1'b0);
        check_d("b2b2", 3'd1, 4'd12, 2'd2, 1'b0, 1'b0, 32'hDEADAAEF);
        do_a(3'd4, 3'd0, 2'd2, 4'd13, 32'd12, 4'hF, 32'd0, 1'b0);
        check_d("b2b3", 3'd1, 4'd13, 2'd2, 1'b0, 1'b0, 32'h11223344);
        idle();
        chk("b2b_drain.d_valid", 32'(tl.d_valid), 32'd0);

        // Backpressure: response held, a_ready low, pending A beat waits
        tl.d_ready = 1'b0;
        do_a(3'd4, 3'd0, 2'd2, 4'd7, 32'd8, 4'hF, 32'd0, 1'b0);
        check_d("hold_first", 3'd1, 4'd7, 2'd2, 1'b0, 1'b0, 32'hDEADAAEF);
        tl.a_opcode  = 3'd4;
        tl.a_source  = 4'd9;
        tl.a_address = 32'd12;
        tl.a_mask    = 4'hF;
        tl.a_size    = 2'd2;
        tl.a_valid   = 1'b1;
        repeat (3) begin
            #1;
            chk("hold.a_ready", 32'(tl.a_ready), 32'd0);
            check_d("hold", 3'd1, 4'd7, 2'd2, 1'b0, 1'b0, 32'hDEADAAEF);
            @(posedge clock);
            #1;
        end
        tl.d_ready = 1'b1;
        #1;
        chk("release.a_ready", 32'(tl.a_ready), 32'd1);
        @(posedge clock);
        #1;
        tl.a_valid = 1'b0;
        check_d("replace", 3'd1, 4'd9, 2'd2, 1'b0, 1'b0, 32'h11223344);
        idle();
        chk("replace_drain.d_valid", 32'(tl.d_valid), 32'd0);

        // Denied requests
        do_a(3'd4, 3'd0, 2'd2, 4'd1, 32'd64, 4'hF, 32'd0, 1'b0);
        check_d("get_out_of_region", 3'd1, 4'd1, 2'd2, 1'b1, 1'b1, 32'd0);
        do_a(3'd4, 3'd0, 2'd3, 4'd2, 32'd0, 4'hF, 32'd0, 1'b0);
        check_d("get_size3", 3'd1, 4'd2, 2'd3, 1'b1, 1'b1, 32'd0);
        do_a(3'd4, 3'd0, 2'd2, 4'd3, 32'd2, 4'hF, 32'd0, 1'b0);
        check_d("get_misaligned", 3'd1, 4'd3, 2'd2, 1'b1, 1'b1, 32'd0);
        do_a(3'd2, 3'd0, 2'd2, 4'd4, 32'd0, 4'hF, 32'd0, 1'b0);
        check_d("opcode2", 3'd0, 4'd4, 2'd2, 1'b1, 1'b0, 32'd0);
        do_a(3'd4, 3'd1, 2'd2, 4'd5, 32'd8, 4'hF, 32'd0, 1'b0);
        check_d("get_param", 3'd1, 4'd5, 2'd2, 1'b1, 1'b1, 32'd0);
        do_a(3'd4, 3'd0, 2'd2, 4'd6, 32'd8, 4'b0111, 32'd0, 1'b0);
        check_d("get_bad_mask", 3'd1, 4'd6, 2'd2, 1'b1, 1'b1, 32'd0);

        // Legal edge cases: last word, half-word Get returns the whole word
        do_a(3'd4, 3'd0, 2'd2, 4'd7, 32'd60, 4'hF, 32'd0, 1'b0);
        check_d("get_last_word", 3'd1, 4'd7, 2'd2, 1'b0, 1'b0, 32'd0);
        do_a(3'd4, 3'd0, 2'd1, 4'd8, 32'd10, 4'b1100, 32'd0, 1'b0);
        check_d("get_half", 3'd1, 4'd8, 2'd1, 1'b0, 1'b0, 32'hDEADAAEF);

        // Poisoned Put is denied and not written
        do_a(3'd0, 3'd0, 2'd2, 4'd9, 32'd0, 4'hF, 32'h12345678, 1'b1);
        check_d("put_corrupt", 3'd0, 4'd9, 2'd2, 1'b1, 1'b0, 32'd0);
        do_a(3'd4, 3'd0, 2'd2, 4'd10, 32'd0, 4'hF, 32'd0, 1'b0);
        check_d("get_after_corrupt", 3'd1, 4'd10, 2'd2, 1'b0, 1'b0, 32'd0);
        idle();

        // Reset during a held response: beat lost, memory cleared
        tl.d_ready = 1'b0;
        do_a(3'd4, 3'd0, 2'd2, 4'd1, 32'd8, 4'hF, 32'd0, 1'b0);
        check_d("pre_reset", 3'd1, 4'd1, 2'd2, 1'b0, 1'b0, 32'hDEADAAEF);
        reset = 1'b0;
        #1;
        chk("mid_reset.d_valid", 32'(tl.d_valid), 32'd0);
        chk("mid_reset.a_ready", 32'(tl.a_ready), 32'd0);
        idle();
        reset = 1'b1;
        tl.d_ready = 1'b1;
        idle();
        do_a(3'd4, 3'd0, 2'd2, 4'd2, 32'd8, 4'hF, 32'd0, 1'b0);
        check_d("get_after_reset", 3'd1, 4'd2, 2'd2, 1'b0, 1'b0, 32'd0);
        idle();

`ifdef TL_UL_SRAM_RESPONDER_ERRCNT_EN
        chk("errcnt.after_reset", 32'(err_count), 32'd0);
        for (int i = 0; i < 3; i++) begin
            do_a(3'd4, 3'd0, 2'd2, 4'd0, 32'd2, 4'hF, 32'd0, 1'b0);
        end
        idle();
        chk("errcnt.three", 32'(err_count), 32'd3);
        for (int i = 0; i < 300; i++) begin
            do_a(3'd4, 3'd0, 2'd2, 4'd0, 32'd2, 4'hF, 32'd0, 1'b0);
        end
        idle();
        chk("errcnt.saturated", 32'(err_count), 32'hFF);
        err_clear = 1'b1;
        idle();
        err_clear = 1'b0;
        chk("errcnt.cleared", 32'(err_count), 32'd0);
        do_a(3'd4, 3'd0, 2'd2, 4'd0, 32'd2, 4'hF, 32'd0, 1'b0);
        err_clear = 1'b1;
        idle();
        err_clear = 1'b0;
        chk("errcnt.clear_wins", 32'(err_count), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
